// File: rtl/umul_pkg.sv
// Shared definitions for the unary-multiplier sequencer: FSM state encoding
// and the default run length of one thermometer-coded bitstream.
package umul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int unsigned BITWIDTH_DEF = 8;
    localparam int unsigned RUN_LEN      = 1 << BITWIDTH_DEF;

endpackage

// File: rtl/umul_seq_ctrl_if.sv
// Request/response bundle between a binary-domain requester and the
// unary multiplier sequencer.
interface umul_seq_ctrl_if #(
    parameter int unsigned BITWIDTH = 8
);
    logic                iStart;
    logic [BITWIDTH-1:0] iA;
    logic [BITWIDTH-1:0] iB;
    logic                iAbort;
    logic                iAck;
    logic                oReady;
    logic                oBusy;
    logic                oValid;
    logic [BITWIDTH-1:0] oProd;

    modport master (
        output iStart, iA, iB, iAbort, iAck,
        input  oReady, oBusy, oValid, oProd
    );

    modport slave (
        input  iStart, iA, iB, iAbort, iAck,
        output oReady, oBusy, oValid, oProd
    );
endinterface

// File: rtl/rep_uMUL.sv
// Unary multiplier: holds B, compares it against a Sobol stream that
// advances only while the A bitstream is 1, and ANDs the result with A.
module rep_uMUL #(
    parameter int unsigned BITWIDTH = 8
) (
    input  logic                iClk,
    input  logic                iRstN,
    input  logic                iA,
    input  logic [BITWIDTH-1:0] iB,
    input  logic                loadB,
    input  logic                iClr,
    output logic                mult
);
    logic [BITWIDTH-1:0] b_q;
    logic [BITWIDTH-1:0] rng;

    sobolrng #(.BITWIDTH(BITWIDTH)) u_rng (
        .iClk     (iClk),
        .iRstN    (iRstN),
        .iEn      (iA),
        .iClr     (iClr),
        .sobolSeq (rng)
    );

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            b_q <= '0;
        end else if (loadB) begin
            b_q <= iB;
        end
    end

    assign mult = iA & (rng < b_q);
endmodule

// File: rtl/sobolrng.sv
// Sobol dimension-1 sequence generator (gray-code form): each enabled cycle
// flips the direction bit selected by the lowest zero bit of the index.
module sobolrng #(
    parameter int unsigned BITWIDTH = 8
) (
    input  logic                iClk,
    input  logic                iRstN,
    input  logic                iEn,
    input  logic                iClr,
    output logic [BITWIDTH-1:0] sobolSeq
);
    logic [BITWIDTH-1:0] idx_q;
    logic [BITWIDTH-1:0] seq_q;
    logic [BITWIDTH-1:0] lz;
    logic [BITWIDTH-1:0] dir;

    // One-hot of the lowest zero bit, bit-reversed into the dim-1 direction number.
    always_comb begin
        lz  = ~idx_q & (idx_q + BITWIDTH'(1));
        dir = '0;
        for (int unsigned i = 0; i < BITWIDTH; i++) begin
            dir[i] = lz[BITWIDTH-1-i];
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            idx_q <= '0;
            seq_q <= '0;
        end else if (iClr) begin
            idx_q <= '0;
            seq_q <= '0;
        end else if (iEn) begin
            idx_q <= idx_q + BITWIDTH'(1);
            seq_q <= seq_q ^ dir;
        end
    end

    assign sobolSeq = seq_q;
endmodule

// File: rtl/umul_seq_ctrl.sv
// Sequencer around one rep_uMUL: latches operands, runs a 2^BITWIDTH-cycle
// thermometer-coded A stream and returns the count of mult ones as the product.
module umul_seq_ctrl
    import umul_pkg::*;
#(
    parameter int unsigned BITWIDTH = 8
) (
    input  logic             iClk,
    input  logic             iRstN,
    umul_seq_ctrl_if.slave   bus
);
    state_e              state_q, state_d;
    logic [BITWIDTH-1:0] a_buf_q, b_buf_q, cnt_q, acc_q, prod_q;
    logic                ready_q, busy_q, valid_q;
    logic                core_a, load_b, mult;

    assign load_b = (state_q == LOAD);
    assign core_a = (state_q == RUN) && (cnt_q < a_buf_q);

    rep_uMUL #(.BITWIDTH(BITWIDTH)) u_mul (
        .iClk  (iClk),
        .iRstN (iRstN),
        .iA    (core_a),
        .iB    (b_buf_q),
        .loadB (load_b),
        .iClr  (load_b),
        .mult  (mult)
    );

    always_comb begin
        state_d = state_q;
        if (bus.iAbort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (bus.iStart)              state_d = LOAD;
                LOAD:                              state_d = RUN;
                RUN:  if (cnt_q == '1)             state_d = DONE;
                DONE: if (valid_q && bus.iAck)     state_d = IDLE;
                default:                           state_d = IDLE;
            endcase
        end
    end

    // oValid is raised on the first DONE cycle, so it appears one edge after the product latch.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            a_buf_q <= '0;
            b_buf_q <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == IDLE);
            busy_q  <= (state_d == LOAD) || (state_d == RUN);
            if (bus.iAbort) begin
                cnt_q   <= '0;
                acc_q   <= '0;
                valid_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (bus.iStart) begin
                        a_buf_q <= bus.iA;
                        b_buf_q <= bus.iB;
                    end
                    LOAD: begin
                        cnt_q <= '0;
                        acc_q <= '0;
                    end
                    RUN: begin
                        cnt_q <= cnt_q + BITWIDTH'(1);
                        if (mult) acc_q <= acc_q + BITWIDTH'(1);
                        if (cnt_q == '1) prod_q <= acc_q + BITWIDTH'(mult);
                    end
                    DONE: begin
                        if (!valid_q)       valid_q <= 1'b1;
                        else if (bus.iAck)  valid_q <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.oReady = ready_q;
    assign bus.oBusy  = busy_q;
    assign bus.oValid = valid_q;
    assign bus.oProd  = prod_q;
endmodule

// File: tb/tb_umul_seq_ctrl.sv
// Scoreboard bench for umul_seq_ctrl: stimulus pushes expected products,
// a negedge monitor pops and compares on every oValid&iAck handshake.
module tb_umul_seq_ctrl;
    import umul_pkg::*;

    localparam int unsigned BW = 8;

    logic clk;
    logic rstn;
    int   compared;
    int   failed;
    int   exp_q[$];
    logic prev_v;

    umul_seq_ctrl_if #(.BITWIDTH(BW)) bus ();

    umul_seq_ctrl #(.BITWIDTH(BW)) dut (
        .iClk  (clk),
        .iRstN (rstn),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // Sobol dim-1 point i = bit-reversed gray code of i.
    function automatic int model(input int a, input int b);
        int c;
        logic [7:0] g;
        logic [7:0] r;
        c = 0;
        for (int i = 0; i < a; i++) begin
            g = 8'(i ^ (i >> 1));
            for (int k = 0; k < 8; k++) r[k] = g[7-k];
            if (int'(r) < b) c++;
        end
        return c;
    endfunction

    always @(negedge clk) begin
        if (!rstn) begin
            prev_v = 1'b0;
        end else begin
            if (bus.oValid && !prev_v) chk("valid_expected", int'(exp_q.size() > 0), 1);
            if (bus.oValid && bus.iAck) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_product", int'(bus.oProd), -1);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    chk("product", int'(bus.oProd), e);
                end
            end
            prev_v = bus.oValid;
        end
    end

    task automatic start_op(input int a, input int b);
        int n;
        n = 0;
        while (!bus.oReady && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_timeout", int'(n >= 2000), 0);
        chk("idle_flags", int'({bus.oReady, bus.oBusy, bus.oValid}), 3'b100);
        bus.iA     = 8'(a);
        bus.iB     = 8'(b);
        bus.iStart = 1'b1;
        @(posedge clk); #1;
        bus.iStart = 1'b0;
        bus.iA     = 8'($urandom);
        bus.iB     = 8'($urandom);
        chk("load_flags", int'({bus.oReady, bus.oBusy, bus.oValid}), 3'b010);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !bus.oReady) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_timeout", int'(n >= 2000), 0);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int k;
        int rec;
        int ok;
        int a;
        int b;
        compared   = 0;
        failed     = 0;
        prev_v     = 1'b0;
        rstn       = 1'b0;
        bus.iStart = 1'b0;
        bus.iA     = '0;
        bus.iB     = '0;
        bus.iAbort = 1'b0;
        bus.iAck   = 1'b0;
        #23;
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready", int'(bus.oReady), 1);
        chk("rst_busy",  int'(bus.oBusy),  0);
        chk("rst_valid", int'(bus.oValid), 0);
        chk("rst_prod",  int'(bus.oProd),  0);

        // 1: latency and stratified product
        exp_q.push_back(64);
        start_op(128, 128);
        k = 0;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clk); #1;
            if (bus.oValid) begin
                k = i;
                break;
            end
        end
        chk("valid_latency", k, RUN_LEN + 2);
        bus.iAck = 1'b1;
        @(posedge clk); #1;
        bus.iAck = 1'b0;
        drain();

        // 2: directed vectors with same-cycle ack
        bus.iAck = 1'b1;
        exp_q.push_back(32); start_op(64, 128);  drain();
        exp_q.push_back(0);  start_op(0, 200);   drain();
        exp_q.push_back(0);  start_op(255, 0);   drain();
        exp_q.push_back(model(255, 255)); start_op(255, 255); drain();

        // 3: back-to-back sweep against the golden model
        for (int i = 0; i < 200; i++) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            exp_q.push_back(model(a, b));
            start_op(a, b);
        end
        drain();

        // 4: start ignored mid-run, product held without ack
        bus.iAck = 1'b0;
        exp_q.push_back(model(100, 50));
        start_op(100, 50);
        idle_cycles(50);
        chk("ready_in_run", int'(bus.oReady), 0);
        bus.iA = 8'd255; bus.iB = 8'd255; bus.iStart = 1'b1;
        @(posedge clk); #1;
        bus.iStart = 1'b0;
        k = 0;
        while (!bus.oValid && k < 400) begin
            @(posedge clk); #1;
            k++;
        end
        chk("valid_timeout", int'(k >= 400), 0);
        rec = int'(bus.oProd);
        ok  = 1;
        repeat (20) begin
            @(posedge clk); #1;
            if (!(bus.oValid && int'(bus.oProd) == rec)) ok = 0;
        end
        chk("valid_hold", ok, 1);
        bus.iAck = 1'b1;
        @(posedge clk); #1;
        bus.iAck = 1'b0;
        idle_cycles(300);
        chk("no_queued_start", int'(bus.oReady), 1);

        // 5: abort at RUN cycle 100
        start_op(128, 128);
        idle_cycles(100);
        bus.iAbort = 1'b1;
        @(posedge clk); #1;
        bus.iAbort = 1'b0;
        chk("abort_flags", int'({bus.oReady, bus.oBusy, bus.oValid}), 3'b100);
        idle_cycles(300);
        bus.iAck = 1'b1;
        exp_q.push_back(64);
        start_op(128, 128);
        drain();

        // 6: asynchronous reset mid-run
        start_op(255, 255);
        idle_cycles(80);
        #2;
        rstn = 1'b0;
        #1;
        chk("midrst_flags", int'({bus.oReady, bus.oBusy, bus.oValid}), 3'b100);
        chk("midrst_prod", int'(bus.oProd), 0);
        #13;
        rstn = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back(model(200, 77));
        start_op(200, 77);
        drain();

        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
endmodule
